// File: rtl/fetch_pkg.sv
// Purpose: shared constants and state type for the IF-stage PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: reset/handler PCs, legal ROM fetch window, RUN/PEND state enum.
package fetch_pkg;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] ROM_LO     = 32'h0000_3000;
   localparam logic [31:0] ROM_HI     = 32'h0000_6FFC;

   // RUN: no redirect waiting; PEND: a redirect arrived during a stall
   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Purpose: bundle of control inputs and PC outputs between ID/CP0 and the fetch sequencer.
// Latency: n/a (wires only).
// Backpressure: Stall holds the PC; there is no other flow control.
// Modports: master = pipeline side (drives Stall/RedirEn/RedirPc/ExcEn/EretEn/Epc),
//           slave  = fetch_ctrl (drives Pc/Pc4/PendValid/FetchAdel).
interface fetch_ctrl_if;

   logic        Stall;
   logic        RedirEn;
   logic [31:0] RedirPc;
   logic        ExcEn;
   logic        EretEn;
   logic [31:0] Epc;
   logic [31:0] Pc;
   logic [31:0] Pc4;
   logic        PendValid;
   logic        FetchAdel;

   modport master (
      output Stall, RedirEn, RedirPc, ExcEn, EretEn, Epc,
      input  Pc, Pc4, PendValid, FetchAdel
   );

   modport slave (
      input  Stall, RedirEn, RedirPc, ExcEn, EretEn, Epc,
      output Pc, Pc4, PendValid, FetchAdel
   );

endinterface

// File: rtl/pc_addr_check.sv
// Purpose: flags a fetch address that is misaligned or outside [lo, hi].
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: pc (in 32), lo (in 32), hi (in 32), adel (out 1).
// The module body only exists when FETCH_ADDR_CHECK_EN is defined, since
// nothing else instantiates it and the default build carries no checker.
`ifdef FETCH_ADDR_CHECK_EN
module pc_addr_check (
   input  logic [31:0] pc,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic        adel
);

   assign adel = (pc[1:0] != 2'b00) | (pc < lo) | (pc > hi);

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Purpose: IF-stage PC sequencer (increment, stall, redirect, exception, ERET, buffered redirect).
// Latency: Pc registered; next Pc visible one cycle after the controlling inputs; Pc4/FetchAdel combinational.
// Backpressure: Stall holds Pc; a redirect seen while stalled is buffered and applied on release.
// Ports: clk, reset (sync, active-high), bus (fetch_ctrl_if.slave).
// Config: FETCH_ADDR_CHECK_EN enables the address checker driving FetchAdel; otherwise FetchAdel=0.
module fetch_ctrl
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   fetch_ctrl_if.slave  bus
);

   logic [31:0]  pc_q, pc_d;
   logic [31:0]  pend_pc_q, pend_pc_d;
   fetch_state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         pend_pc_q <= 32'h0;
         state_q   <= RUN;
      end else begin
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         state_q   <= state_d;
      end
   end

   // Next-PC priority: exception > ERET > stalled redirect (buffer) >
   // live redirect > release of buffered redirect > stall > increment.
   always_comb begin
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      state_d   = state_q;
      if (bus.ExcEn) begin
         pc_d      = HANDLER_PC;
         pend_pc_d = 32'h0;
         state_d   = RUN;
      end else if (bus.EretEn) begin
         pc_d      = bus.Epc;
         pend_pc_d = 32'h0;
         state_d   = RUN;
      end else if (bus.RedirEn && bus.Stall) begin
         // latest redirect wins if one is already buffered
         pend_pc_d = bus.RedirPc;
         state_d   = PEND;
      end else if (bus.RedirEn) begin
         pc_d      = bus.RedirPc;
         state_d   = RUN;
      end else if ((state_q == PEND) && !bus.Stall) begin
         pc_d      = pend_pc_q;
         state_d   = RUN;
      end else if (!bus.Stall) begin
         pc_d      = pc_q + 32'd4;
      end
   end

   assign bus.Pc        = pc_q;
   assign bus.Pc4       = pc_q + 32'd4;
   assign bus.PendValid = (state_q == PEND);

`ifdef FETCH_ADDR_CHECK_EN
   // Pc still drives the ROM unchanged; CP0 decides whether to trap.
   pc_addr_check u_pc_addr_check (
      .pc   (pc_q),
      .lo   (ROM_LO),
      .hi   (ROM_HI),
      .adel (bus.FetchAdel)
   );
`else
   assign bus.FetchAdel = 1'b0;
`endif

endmodule
